// File: rtl/md_sched_if.sv
// EX-stage <-> md_sched <-> HI/LO multiply/divide unit signal bundle.
// An md request is consumed in the cycle md_req=1, flush=0 and stall=0; with stall=1 the EX stage holds it.
interface md_sched_if;
   logic        md_req;
   logic [2:0]  md_func;
   logic        flush;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        md_busy;
   logic        stall;
   logic        md_start;
   logic [1:0]  md_op;
   logic        md_we;
   logic        md_hilo;
   logic [31:0] md_d1;
   logic [31:0] md_d2;
   logic        dz_err;
   logic        err;

   modport slave (
      input  md_req, md_func, flush, rs_data, rt_data, md_busy,
      output stall, md_start, md_op, md_we, md_hilo, md_d1, md_d2, dz_err, err
   );

   modport master (
      output md_req, md_func, flush, rs_data, rt_data, md_busy,
      input  stall, md_start, md_op, md_we, md_hilo, md_d1, md_d2, dz_err, err
   );
endinterface

// File: rtl/md_sched.sv
// Issue/hazard controller for the multi-cycle HI/LO multiply/divide unit:
// issues md ops, stalls racing md requests for LAT cycles, drops divide-by-zero.
module md_sched #(
   parameter int LAT  = 5,
   parameter int WDOG = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   md_sched_if.slave  md,
   output logic [1:0] state_o
);
   localparam int CW = $clog2(LAT + 1);
   localparam int WW = $clog2(WDOG + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic            err_q, err_d;

   logic req, busy, free, rt_zero, is_div, start, we, dz;

   always_comb begin
      req     = md.md_req & ~md.flush;
      busy    = (state_q != S_IDLE) | md.md_busy;
      free    = req & ~busy;
      rt_zero = (md.rt_data == 32'd0);
      is_div  = md.md_func[1] & ~md.md_func[2];
      start   = free & ~md.md_func[2] & ~(md.md_func[1] & rt_zero);
      we      = free & md.md_func[2] & ~md.md_func[1];
      dz      = free & is_div & rt_zero;
   end

   // Every output is forced low in the reset cycle, including the registered Err.
   always_comb begin
      md.stall    = ~rst_i & req & busy;
      md.md_start = ~rst_i & start;
      md.md_op    = (~rst_i & start) ? md.md_func[1:0] : 2'd0;
      md.md_we    = ~rst_i & we;
      md.md_hilo  = ~rst_i & md.md_func[0];
      md.md_d1    = rst_i ? 32'd0 : md.rs_data;
      md.md_d2    = rst_i ? 32'd0 : md.rt_data;
      md.dz_err   = ~rst_i & dz;
      md.err      = ~rst_i & err_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = CW'(LAT);
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = md.md_busy ? S_DRAIN : S_IDLE;
            end
         end
         S_DRAIN: begin
            // Watchdog counter saturates; Err is sticky so re-setting it is harmless.
            if (!md.md_busy) begin
               state_d = S_IDLE;
               wcnt_d  = '0;
            end else if (wcnt_q == WW'(WDOG - 1)) begin
               err_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            wcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   assign state_o = state_q;
endmodule
